// File: rtl/int_ctrl.sv
// Interrupt/trap sequencer beside EX: saves mepc/mcause/mstatus on ecall or an enabled IRQ,
// restores mstatus on mret, then redirects fetch through EX for exactly one cycle.
module int_ctrl #(
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       CSR_AW       = 5,
  parameter int unsigned       NUM_IRQ      = 4,
  parameter logic [CSR_AW-1:0] MSTATUS_ADDR = CSR_AW'(0),
  parameter logic [CSR_AW-1:0] MEPC_ADDR    = CSR_AW'(1),
  parameter logic [CSR_AW-1:0] MCAUSE_ADDR  = CSR_AW'(2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inst_ecall,
  input  logic               inst_mret,
  input  logic               ex_valid,
  input  logic [DATA_W-1:0]  ex_pc,
  input  logic               ex_jump_flag,
  input  logic [DATA_W-1:0]  ex_jump_pc,
  input  logic [DATA_W-1:0]  csr_mstatus,
  input  logic [DATA_W-1:0]  csr_mie,
  input  logic [DATA_W-1:0]  csr_mtvec,
  input  logic [DATA_W-1:0]  csr_mepc,
  output logic               int_we,
  output logic [CSR_AW-1:0]  int_waddr,
  output logic [DATA_W-1:0]  int_wdata,
  output logic               int_assert,
  output logic [DATA_W-1:0]  int_inst_addr,
  output logic               hold_req
);

  if (NUM_IRQ == 0 || NUM_IRQ > 16) begin : gen_bad_num_irq
    $error("int_ctrl: NUM_IRQ must be in 1..16");
  end

  typedef enum logic [2:0] {
    StIdle,
    StSaveEpc,
    StSaveCause,
    StSaveStatus,
    StRestore,
    StRedirect
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] ret_pc_q;
  logic [DATA_W-1:0] cause_q;
  logic [DATA_W-1:0] old_mstatus_q;

  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_take;
  logic [4:0]         irq_idx;
  logic [DATA_W-1:0]  irq_ret_pc;
  logic [DATA_W-1:0]  irq_cause;
  logic [DATA_W-1:0]  save_status;
  logic [DATA_W-1:0]  restore_status;

  logic unused_mie;
  assign unused_mie = ^csr_mie[DATA_W-1:NUM_IRQ];

  always_comb begin
    irq_pend = irq & csr_mie[NUM_IRQ-1:0];
    irq_take = csr_mstatus[3] && (irq_pend != '0);
    // Scan downwards so the lowest active line is the one left standing.
    irq_idx = '0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (irq_pend[k]) irq_idx = 5'(k);
    end
    // An interrupted instruction completes, so return past it (or to its branch target).
    irq_ret_pc = ex_jump_flag ? ex_jump_pc : ex_pc + DATA_W'(4);
    irq_cause             = '0;
    irq_cause[DATA_W-1]   = 1'b1;
    irq_cause[4:0]        = 5'd16 + irq_idx;
    save_status           = old_mstatus_q;
    save_status[7]        = old_mstatus_q[3];
    save_status[3]        = 1'b0;
    restore_status        = csr_mstatus;
    restore_status[3]     = csr_mstatus[7];
    restore_status[7]     = 1'b1;
  end

  // Outputs are loaded on the edge that enters a state, so each state's strobes are
  // visible for exactly the cycle spent in it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ret_pc_q      <= '0;
      cause_q       <= '0;
      old_mstatus_q <= '0;
      int_we        <= 1'b0;
      int_waddr     <= '0;
      int_wdata     <= '0;
      int_assert    <= 1'b0;
      int_inst_addr <= '0;
      hold_req      <= 1'b0;
    end else begin
      int_we        <= 1'b0;
      int_waddr     <= '0;
      int_wdata     <= '0;
      int_assert    <= 1'b0;
      int_inst_addr <= '0;
      hold_req      <= 1'b1;
      unique case (state_q)
        StIdle: begin
          hold_req <= 1'b0;
          if (ex_valid && (inst_ecall || inst_mret || irq_take)) begin
            old_mstatus_q <= csr_mstatus;
            hold_req      <= 1'b1;
            int_we        <= 1'b1;
            if (inst_ecall) begin
              ret_pc_q  <= ex_pc;
              cause_q   <= DATA_W'(11);
              int_waddr <= MEPC_ADDR;
              int_wdata <= ex_pc;
              state_q   <= StSaveEpc;
            end else if (inst_mret) begin
              int_waddr <= MSTATUS_ADDR;
              int_wdata <= restore_status;
              state_q   <= StRestore;
            end else begin
              ret_pc_q  <= irq_ret_pc;
              cause_q   <= irq_cause;
              int_waddr <= MEPC_ADDR;
              int_wdata <= irq_ret_pc;
              state_q   <= StSaveEpc;
            end
          end
        end
        StSaveEpc: begin
          int_we    <= 1'b1;
          int_waddr <= MCAUSE_ADDR;
          int_wdata <= cause_q;
          state_q   <= StSaveCause;
        end
        StSaveCause: begin
          int_we    <= 1'b1;
          int_waddr <= MSTATUS_ADDR;
          int_wdata <= save_status;
          state_q   <= StSaveStatus;
        end
        StSaveStatus: begin
          int_assert    <= 1'b1;
          int_inst_addr <= csr_mtvec;
          state_q       <= StRedirect;
        end
        StRestore: begin
          int_assert    <= 1'b1;
          int_inst_addr <= csr_mepc;
          state_q       <= StRedirect;
        end
        StRedirect: begin
          hold_req <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          hold_req <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt/trap sequencer sitting beside the EX stage; sole owner of the CSR file's second write port.
- On an ecall or an enabled external IRQ it stalls the pipeline and writes mepc, mcause and mstatus in fixed order.
- It then drives int_assert/int_inst_addr into EX for one cycle to redirect fetch to mtvec.
- On mret it restores mstatus and redirects fetch to mepc.

Parameters:
- DATA_W, 32, CSR/PC data width
- CSR_AW, 5, CSR address width
- NUM_IRQ, 4, number of external level-sensitive IRQ lines
- MSTATUS_ADDR, 5'd0, CSR address of mstatus
- MEPC_ADDR, 5'd1, CSR address of mepc
- MCAUSE_ADDR, 5'd2, CSR address of mcause

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- irq  in  NUM_IRQ  external interrupt lines, level, active-high
- inst_ecall  in  1  EX holds a valid ecall
- inst_mret  in  1  EX holds a valid mret
- ex_valid  in  1  EX holds a non-bubble instruction
- ex_pc  in  DATA_W  PC of the EX instruction
- ex_jump_flag  in  1  EX jump_flag
- ex_jump_pc  in  DATA_W  EX jump_pc
- csr_mstatus  in  DATA_W  current mstatus (bit3 MIE, bit7 MPIE)
- csr_mie  in  DATA_W  per-line enables; bit k enables irq[k]
- csr_mtvec  in  DATA_W  handler base address
- csr_mepc  in  DATA_W  current mepc
- int_we  out  1  CSR write enable
- int_waddr  out  CSR_AW  CSR write address
- int_wdata  out  DATA_W  CSR write data
- int_assert  out  1  redirect strobe into EX
- int_inst_addr  out  DATA_W  redirect target
- hold_req  out  1  pipeline stall; EX is fed bubbles and its CSR write is suppressed

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous, active-low (rst_n sampled on the clk rising edge).
- Reset values:
  - State returns to IDLE.
  - All outputs are 0.
  - Internal latches (ret_pc, cause, old_mstatus) are 0.
- Output timing: all outputs are registered from state, with no combinational path from inputs.
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RESTORE, REDIRECT.
- hold_req is 1 in every state except IDLE.
- IDLE event detection, evaluated only when ex_valid=1. Priority order:
  1. inst_ecall: always taken, regardless of MIE.
     - ret_pc = ex_pc.
     - cause = 32'd11.
     - Next state SAVE_EPC.
  2. inst_mret: next state RESTORE.
  3. Async interrupt: taken only when mstatus[3]=1 and (irq & csr_mie[NUM_IRQ-1:0]) != 0.
     - Lowest-index active line wins.
     - ret_pc = ex_jump_flag ? ex_jump_pc : ex_pc+4 (the EX instruction completes).
     - cause = 32'h8000_0000 | (16+k).
     - Next state SAVE_EPC.
  - Detection also latches old_mstatus = csr_mstatus.
- Save sequence, one CSR write per state:
  - SAVE_EPC: int_we=1, int_waddr=MEPC_ADDR, int_wdata=ret_pc.
  - SAVE_CAUSE: int_we=1, int_waddr=MCAUSE_ADDR, int_wdata=cause.
  - SAVE_STATUS: int_we=1, int_waddr=MSTATUS_ADDR, int_wdata=old_mstatus with bit7=old bit3 and bit3=0.
  - Then REDIRECT with target=csr_mtvec, sampled in SAVE_STATUS.
- RESTORE:
  - int_we=1, int_waddr=MSTATUS_ADDR, int_wdata=old_mstatus with bit3=old bit7 and bit7=1.
  - Target=csr_mepc, sampled in RESTORE.
  - Then REDIRECT.
- REDIRECT:
  - int_assert=1 and int_inst_addr=target for exactly one cycle; int_we=0.
  - Next state IDLE.
  - No new event is accepted in the REDIRECT cycle.
- Latency:
  - Trap: detection cycle N; writes in N+1..N+3; int_assert in N+4; hold_req high N+1..N+4.
  - mret: write in N+1; int_assert in N+2.
- Boundary conditions:
  - IRQs arriving mid-sequence are ignored (not latched). They are taken later only if still asserted and enabled.
  - ecall with a simultaneous IRQ: ecall is taken. Because MIE is cleared, the IRQ waits for mret.
  - ecall and mret both asserted: ecall wins. This is a decode error case, but must be deterministic.
  - ex_valid=0: no event is detected.
  - Reset in any state returns to IDLE next edge with all outputs 0. A partially written CSR set is not repaired.
  - ex_pc+4 wraps modulo 2^DATA_W.
  - NUM_IRQ must be ≤ 16.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all inputs active -> every output 0, state IDLE, no int_we.
- ecall: ecall at ex_pc=0x100, mstatus=0x8, mtvec=0x200 ->
  - writes mepc=0x100, mcause=0xB, mstatus=0x80 on consecutive cycles;
  - int_assert=1 with int_inst_addr=0x200 on the 4th cycle after detection;
  - hold_req high for 4 cycles.
- IRQ with taken branch: irq=4'b0110, mie=0xF, MIE=1, ex_pc=0x40, ex_jump_flag=1, jump_pc=0x80 ->
  - mepc=0x80, mcause=0x8000_0011.
  - Repeat with ex_jump_flag=0 -> mepc=0x44.
- Masking: irq=4'b0001 with mie=0 or MIE=0 -> no activity for 20 cycles. Setting MIE=1 with mie[0]=1 -> trap begins the same cycle.
- mret: mret with mstatus=0x80, mepc=0x104 -> writes mstatus=0x88, then int_assert with int_inst_addr=0x104 two cycles after detection.
- Reset mid-sequence and simultaneity:
  - rst_n=0 during SAVE_CAUSE -> IDLE next edge, outputs 0.
  - Simultaneous ecall+irq -> mcause=0xB, no second trap until mret.
